// File: rtl/trimem_pkg.sv
// -----------------------------------------------------------------------------
// trimem_pkg
//   Shared definitions for the trimem_initiator slice:
//     - trit encodings (TRIT_Z / TRIT_P / TRIT_N / TRIT_BAD)
//     - rsp_err codes returned to the core
//     - FSM state encoding of the initiator
//     - trit_is_bad(): helper used by the address checker
// -----------------------------------------------------------------------------
package trimem_pkg;

  // Two bits per trit. 2'b10 is not a legal trit.
  localparam logic [1:0] TRIT_Z   = 2'b00;  //  0
  localparam logic [1:0] TRIT_P   = 2'b01;  // +1
  localparam logic [1:0] TRIT_N   = 2'b11;  // -1
  localparam logic [1:0] TRIT_BAD = 2'b10;  // illegal code

  localparam int TRYTE_TRITS = 9;
  localparam int TRYTE_W     = 2 * TRYTE_TRITS;

  // Response error codes.
  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_PAGEFAULT = 2'b01;
  localparam logic [1:0] ERR_BADADDR   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic trit_is_bad(input logic [1:0] t);
    return (t == TRIT_BAD);
  endfunction

endpackage

// File: rtl/trimem_initiator_tryte_valid.sv
// -----------------------------------------------------------------------------
// tryte_valid
//   Combinational legality check of one tryte.
//   Ports:
//     tryte  in  18  nine trits, trit i in bits [2i+1:2i]
//     valid  out 1   1 when no trit carries the illegal code 2'b10
// -----------------------------------------------------------------------------
module tryte_valid
  import trimem_pkg::*;
(
  input  logic [TRYTE_W-1:0] tryte,
  output logic               valid
);

  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < TRYTE_TRITS; i++) begin
      if (trit_is_bad(tryte[2*i +: 2])) begin
        valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/trimem_initiator.sv
// -----------------------------------------------------------------------------
// trimem_initiator
//   Requester-side sequencer for the ternary RAM access protocol. Takes one
//   load/store command at a time from the core, rejects illegal addresses
//   locally, pulses the RAM enable for one cycle, waits for the RAM reply and
//   returns a single response word with an error code.
//
//   Parameters:
//     TIMEOUT        WAIT cycles without ram_o before the access is abandoned
//                    (only used when TRIMEM_TIMEOUT_EN is defined), >= 1
//
//   Build option:
//     TRIMEM_TIMEOUT_EN  when defined, a WAIT-cycle counter abandons the access
//                        with err 11 after TIMEOUT cycles; when undefined the
//                        block waits for ram_o indefinitely.
//
//   Ports:
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     req_valid/req_ready      command handshake from the core
//     req_write/pt/addr/data   command payload (store=1, page type, address, data)
//     rsp_valid/rsp_ready      response handshake to the core
//     rsp_err/rsp_data         error code and load data (0 for stores/errors)
//     ram_e                    one-cycle RAM enable pulse
//     ram_write/pt/addr/in     latched command driven to the RAM
//     ram_o/pagefault/out      RAM reply; pagefault and out valid with ram_o
//     dbg_state                current FSM state (state_t encoding)
//
//   Handshakes: a transfer happens on a rising edge where valid & ready are
//   both 1. Once rsp_valid is raised, rsp_err and rsp_data do not change until
//   that transfer. req_ready depends only on the FSM state, never on req_valid.
// -----------------------------------------------------------------------------
module trimem_initiator
  import trimem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_pt,
  input  logic [17:0]  req_addr,
  input  logic [17:0]  req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_err,
  output logic [17:0]  rsp_data,
  output logic         ram_e,
  output logic         ram_write,
  output logic [1:0]   ram_pt,
  output logic [17:0]  ram_addr,
  output logic [17:0]  ram_in,
  input  logic         ram_o,
  input  logic         ram_pagefault,
  input  logic [17:0]  ram_out,
  output logic [1:0]   dbg_state
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("trimem_initiator: TIMEOUT must be >= 1");
  end

  state_t state, state_nxt;
  logic   addr_ok;
  logic   timeout_hit;

  tryte_valid u_addr_chk (
    .tryte (req_addr),
    .valid (addr_ok)
  );

`ifdef TRIMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_COUNT = CW'(TIMEOUT);

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_inc;

  // wait_cnt holds the number of WAIT cycles already completed, so the
  // current WAIT cycle is number wait_cnt+1. The access is abandoned at the
  // end of the TIMEOUT-th WAIT cycle.
  assign wait_cnt_inc = wait_cnt + 1'b1;
  assign timeout_hit  = (wait_cnt_inc == TO_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      // ISSUE always precedes WAIT, so clearing here clears on WAIT entry.
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt_inc;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_e     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = addr_ok ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        ram_e     = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // ram_o takes priority over an expiring timeout in the same cycle.
        if (ram_o || timeout_hit) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Command latch (drives the RAM) and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_write <= 1'b0;
      ram_pt    <= 2'b00;
      ram_addr  <= '0;
      ram_in    <= '0;
      rsp_err   <= ERR_OK;
      rsp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            ram_write <= req_write;
            ram_pt    <= req_pt;
            ram_addr  <= req_addr;
            ram_in    <= req_data;
            if (!addr_ok) begin
              rsp_err  <= ERR_BADADDR;
              rsp_data <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (ram_o) begin
            rsp_err  <= ram_pagefault ? ERR_PAGEFAULT : ERR_OK;
            // Only a clean load returns data; stores and faults return 0.
            rsp_data <= (!ram_write && !ram_pagefault) ? ram_out : '0;
          end else if (timeout_hit) begin
            rsp_err  <= ERR_TIMEOUT;
            rsp_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/trimem_initiator.md
# trimem_initiator

Requester-side sequencer for the ternary RAM (`triram`) access protocol. It accepts single load/store commands from the core over a valid/ready handshake and rejects malformed addresses locally. For each accepted command it drives the RAM's one-cycle enable pulse, waits for the RAM's ready/pagefault reply and returns one response word with an error code. It sits between the core's execute stage and `triram`, with exactly one access outstanding.

## Interface
- `TIMEOUT`, 15: number of WAIT cycles without `ram_o` before the access is abandoned; must be ≥1.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core command valid.
- `req_ready`  out  1  block can accept a command.
- `req_write`  in  1  1 = store, 0 = load.
- `req_pt`  in  2  signed page type, −1/0/+1; the value 2'b10 is never driven.
- `req_addr`  in  18  tryte address, 9 trits × 2 bits.
- `req_data`  in  18  store data tryte.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  core accepts the response.
- `rsp_err`  out  2  00 ok, 01 pagefault, 10 bad address, 11 timeout.
- `rsp_data`  out  18  load data; 0 for stores and for any error.
- `ram_e`  out  1  RAM enable pulse.
- `ram_write`  out  1  RAM write select.
- `ram_pt`  out  2  RAM page type.
- `ram_addr`  out  18  RAM address.
- `ram_in`  out  18  RAM write data.
- `ram_o`  in  1  RAM ready.
- `ram_pagefault`  in  1  RAM access faulted; valid with `ram_o`.
- `ram_out`  in  18  RAM read data; valid with `ram_o`.

## Operation
- Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b11 = −1. 2'b10 is invalid.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `req_ready` = 1.
  - On `req_valid & req_ready`, latch write, pt, addr and data.
  - If any address trit is 2'b10: go to RESP with err 10. No RAM pulse is issued.
  - Otherwise go to ISSUE.
- **ISSUE:** `ram_e` = 1 for exactly this cycle. `ram_write`, `ram_pt`, `ram_addr` and `ram_in` show the latched values. Next state is WAIT.
- **WAIT:** `ram_o` is sampled each cycle.
  - When `ram_o` = 1, capture the reply and go to RESP.
  - err = 01 if `ram_pagefault`, else 00.
  - data = `ram_out` when the access is a load with err 00, else 0.
- **RESP:** `rsp_valid` = 1. `rsp_err` and `rsp_data` are held stable until `rsp_valid & rsp_ready`, then the FSM returns to IDLE.
- `ram_o` is ignored in IDLE, ISSUE and RESP.
- `ram_*` address/data outputs hold their latched values outside ISSUE. `ram_e` is 0 outside ISSUE.

## Timing
- Reset values: state IDLE; `req_ready` = 1; `rsp_valid` = 0; `rsp_err` = 0; `rsp_data` = 0; `ram_e` = 0; `ram_write` = 0; `ram_pt` = 0; `ram_addr` = 0; `ram_in` = 0; timeout counter = 0.
- Latency for a command accepted in cycle N:
  - `ram_e` is high in cycle N+1.
  - With `ram_o` high in cycle N+2, `rsp_valid` rises in cycle N+3.
  - For a bad address, `rsp_valid` rises in cycle N+1.
- Back-to-back: a new command can be accepted in the cycle after the response handshake. `req_ready` is 0 in ISSUE, WAIT and RESP.
- Reset in any state takes effect at the next edge. An in-flight RAM reply arriving after reset is ignored.

## Configuration
- `TRIMEM_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) counts WAIT cycles.
  - When it reaches `TIMEOUT` without `ram_o`, the FSM goes to RESP with err 11 and data 0.
  - If `ram_o` arrives in the same cycle the count is reached, `ram_o` wins.
  - The counter clears on entering WAIT.
- `TRIMEM_TIMEOUT_EN` undefined: there is no counter, WAIT lasts until `ram_o`, and err 11 is never produced.

## Structure
- The shared header (alongside `utils.h`) holds:
  - the trit encoding constants `TRIT_Z`, `TRIT_P`, `TRIT_N` and `TRIT_BAD`;
  - the `rsp_err` code constants;
  - the FSM state encodings.
- Sub-module `tryte_valid`: combinational; input 18 bits, output 1 = no trit equals 2'b10. It is instantiated once on `req_addr`.

## Test plan
- Bench the block against the `triram` model; psw = 0. Load, pt 0, addr 0, `rsp_ready` = 1 → `ram_e` one cycle; `rsp_valid` in cycle N+3; err 00; data 18'b111111000000000000.
- Load, pt −1, addr int 1916, with the psw trit for pt set to 2'b01 → err 01, data 0. Repeat with psw = 0 → err 00, data 18'b111111000011000000.
- addr 18'b000000000000000010 → no `ram_e` pulse; `rsp_valid` in cycle N+1; err 10.
- Stub RAM that never asserts `ram_o`, `TIMEOUT` = 15, macro on → err 11 with `rsp_valid` rising at cycle N+17. Macro off → `rsp_valid` still 0 after 100 cycles.
- Load of addr int 697 with `rsp_ready` held low for 4 cycles → `rsp_valid`, `rsp_err` and `rsp_data` (18'b111111001101000100) stable; `req_ready` = 0 throughout; the next command is accepted the cycle after the handshake.
- `rst` asserted in WAIT, with `ram_o` arriving the cycle after → all outputs at reset values; no `rsp_valid` pulse.
